// File: rtl/tdc_bringup_sequencer.sv
// Power-up / soft-reset sequencer for an array of TDC front-ends, driven by single-byte
// ASCII commands. Holds enable low, waits for boot, then pulses each masked channel in turn.
module tdc_bringup_sequencer #(
    parameter int unsigned NUM_CH          = 6,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned ENABLE_LOW_CYC  = 16,
    parameter int unsigned BOOT_CYC        = 1000000,
    parameter int unsigned RESET_PULSE_CYC = 2,
    parameter int unsigned RESET_GAP_CYC   = 3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] tdc_enable,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              go_home,
    output logic              pause,
    output logic              busy,
    output logic              seq_done
);

    // Wide enough to hold NUM_CH, the "past the last channel" start index.
    localparam int unsigned CH_W = $clog2(NUM_CH + 1);

    localparam logic [7:0] CmdBringup  = 8'h64; // 'd'
    localparam logic [7:0] CmdResetOnly = 8'h72; // 'r'
    localparam logic [7:0] CmdShutdown = 8'h78; // 'x'
    localparam logic [7:0] CmdHomeSet  = 8'h68; // 'h'
    localparam logic [7:0] CmdHomeClr  = 8'h63; // 'c'
    localparam logic [7:0] CmdPauseSet = 8'h73; // 's'
    localparam logic [7:0] CmdPauseClr = 8'h70; // 'p'

    typedef enum logic [2:0] {
        StIdle,
        StEnLow,
        StBootWait,
        StRstPulse,
        StRstGap
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               en_q, en_d;
    logic [NUM_CH-1:0]  soft_reset_q, soft_reset_d;
    logic               go_home_q, go_home_d;
    logic               pause_q, pause_d;
    logic               busy_q, busy_d;
    logic               seq_done_q, seq_done_d;

    logic               sel_go;
    logic [CH_W-1:0]    sel_start;
    logic [NUM_CH-1:0]  sel_mask;
    logic               sel_found;
    logic [CH_W-1:0]    sel_ch;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        ch_d       = ch_q;
        mask_d     = mask_q;
        en_d       = en_q;
        go_home_d  = go_home_q;
        pause_d    = pause_q;
        seq_done_d = 1'b0;
        sel_go     = 1'b0;
        sel_start  = '0;
        sel_mask   = mask_q;
        sel_found  = 1'b0;
        sel_ch     = '0;

        case (state_q)
            StEnLow: begin
                if (cnt_q == CNT_W'(ENABLE_LOW_CYC - 1)) begin
                    state_d = StBootWait;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StBootWait: begin
                if (cnt_q == CNT_W'(BOOT_CYC - 1)) begin
                    sel_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRstPulse: begin
                if (cnt_q == CNT_W'(RESET_PULSE_CYC - 1)) begin
                    state_d = StRstGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRstGap: begin
                if (cnt_q == CNT_W'(RESET_GAP_CYC - 1)) begin
                    sel_go    = 1'b1;
                    sel_start = ch_q + CH_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Commands override the timed progression above.
        if (rx_valid) begin
            case (rx_data)
                CmdBringup: begin
                    go_home_d = 1'b0;
                    mask_d    = ch_mask;
                    state_d   = StEnLow;
                    cnt_d     = '0;
                    ch_d      = '0;
                    en_d      = 1'b0;
                    sel_go    = 1'b0;
                end
                CmdResetOnly: begin
                    if (state_q == StIdle && en_q) begin
                        mask_d    = ch_mask;
                        sel_mask  = ch_mask;
                        sel_go    = 1'b1;
                        sel_start = '0;
                    end
                end
                CmdShutdown: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    ch_d    = '0;
                    en_d    = 1'b0;
                    sel_go  = 1'b0;
                end
                CmdHomeSet:  go_home_d = 1'b1;
                CmdHomeClr:  go_home_d = 1'b0;
                CmdPauseSet: pause_d   = 1'b1;
                CmdPauseClr: pause_d   = 1'b0;
                default: ;
            endcase
        end

        // Channel select: lowest enabled channel at or above sel_start, zero cycles.
        if (sel_go) begin
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (sel_mask[i] && (i >= int'(sel_start))) begin
                    sel_found = 1'b1;
                    sel_ch    = CH_W'(i);
                end
            end
            cnt_d = '0;
            if (sel_found) begin
                state_d = StRstPulse;
                ch_d    = sel_ch;
            end else begin
                state_d    = StIdle;
                ch_d       = '0;
                seq_done_d = 1'b1;
            end
        end

        soft_reset_d = (state_d == StRstPulse) ? (NUM_CH'(1) << ch_d) : '0;
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ch_q         <= '0;
            mask_q       <= '0;
            en_q         <= 1'b0;
            soft_reset_q <= '0;
            go_home_q    <= 1'b0;
            pause_q      <= 1'b0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            mask_q       <= mask_d;
            en_q         <= en_d;
            soft_reset_q <= soft_reset_d;
            go_home_q    <= go_home_d;
            pause_q      <= pause_d;
            busy_q       <= busy_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign tdc_enable = {NUM_CH{en_q}};
    assign soft_reset = soft_reset_q;
    assign go_home    = go_home_q;
    assign pause      = pause_q;
    assign busy       = busy_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_tdc_bringup_sequencer.sv
// Bench for tdc_bringup_sequencer: per-scenario waveform tables of expected outputs,
// pushed to a scoreboard as each cycle's stimulus is driven and popped after the edge.
module tb_tdc_bringup_sequencer;

    localparam logic [7:0] C_D = 8'h64;
    localparam logic [7:0] C_R = 8'h72;
    localparam logic [7:0] C_X = 8'h78;
    localparam logic [7:0] C_H = 8'h68;
    localparam logic [7:0] C_C = 8'h63;
    localparam logic [7:0] C_S = 8'h73;
    localparam logic [7:0] C_P = 8'h70;
    localparam logic [7:0] C_Z = 8'h7a;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [2:0] ch_mask = 3'b000;
    logic [2:0] tdc_enable;
    logic [2:0] soft_reset;
    logic       go_home;
    logic       pause;
    logic       busy;
    logic       seq_done;

    always #5 clk = ~clk;

    tdc_bringup_sequencer #(
        .NUM_CH         (3),
        .CNT_W          (8),
        .ENABLE_LOW_CYC (4),
        .BOOT_CYC       (10),
        .RESET_PULSE_CYC(2),
        .RESET_GAP_CYC  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ch_mask   (ch_mask),
        .tdc_enable(tdc_enable),
        .soft_reset(soft_reset),
        .go_home   (go_home),
        .pause     (pause),
        .busy      (busy),
        .seq_done  (seq_done)
    );

    typedef struct {
        int         lo;
        int         hi;
        logic       en;
        logic [2:0] sr;
        logic       bz;
        logic       dn;
    } seg_t;

    typedef struct {
        int         cyc;
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       mset;
        logic [2:0] mask;
    } ev_t;

    typedef struct {
        logic [2:0] en;
        logic [2:0] sr;
        logic       gh;
        logic       ps;
        logic       bz;
        logic       dn;
    } exp_t;

    seg_t seg_q[$];
    ev_t  ev_q[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic gh_m = 1'b0;
    logic ps_m = 1'b0;

    task automatic new_scn();
        seg_q.delete();
        ev_q.delete();
    endtask

    task automatic sg(input int lo, input int hi, input logic en, input logic [2:0] sr,
                      input logic bz, input logic dn);
        seg_q.push_back('{lo, hi, en, sr, bz, dn});
    endtask

    task automatic cmd(input int c, input logic [7:0] d);
        ev_q.push_back('{c, 1'b0, 1'b1, d, 1'b0, 3'b000});
    endtask

    task automatic rst_at(input int c);
        ev_q.push_back('{c, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000});
    endtask

    task automatic mask_at(input int c, input logic [2:0] m);
        ev_q.push_back('{c, 1'b0, 1'b0, 8'h00, 1'b1, m});
    endtask

    function automatic exp_t lookup(input int c);
        exp_t e;
        e = '{en: 3'b000, sr: 3'b000, gh: 1'b0, ps: 1'b0, bz: 1'b0, dn: 1'b0};
        foreach (seg_q[k]) begin
            if (c >= seg_q[k].lo && c <= seg_q[k].hi) begin
                e.en = {3{seg_q[k].en}};
                e.sr = seg_q[k].sr;
                e.bz = seg_q[k].bz;
                e.dn = seg_q[k].dn;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int c, input exp_t e);
        n_tests++;
        if ({tdc_enable, soft_reset, go_home, pause, busy, seq_done} !==
            {e.en, e.sr, e.gh, e.ps, e.bz, e.dn}) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got en=%b sr=%b gh=%b ps=%b busy=%b done=%b, want en=%b sr=%b gh=%b ps=%b busy=%b done=%b",
                     name, c, tdc_enable, soft_reset, go_home, pause, busy, seq_done,
                     e.en, e.sr, e.gh, e.ps, e.bz, e.dn);
        end
    endtask

    // Drive cycle t from the event list, queue the expectation for cycle t+1, then compare.
    task automatic run(input string name, input int len);
        for (int t = 0; t < len; t++) begin
            exp_t e;
            rst      = 1'b0;
            rx_valid = 1'b0;
            rx_data  = 8'h00;
            foreach (ev_q[k]) begin
                if (ev_q[k].cyc == t) begin
                    if (ev_q[k].rst) begin
                        rst  = 1'b1;
                        gh_m = 1'b0;
                        ps_m = 1'b0;
                    end
                    if (ev_q[k].mset) ch_mask = ev_q[k].mask;
                    if (ev_q[k].vld) begin
                        rx_valid = 1'b1;
                        rx_data  = ev_q[k].data;
                        case (ev_q[k].data)
                            C_H:      gh_m = 1'b1;
                            C_C, C_D: gh_m = 1'b0;
                            C_S:      ps_m = 1'b1;
                            C_P:      ps_m = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            e    = lookup(t + 1);
            e.gh = gh_m;
            e.ps = ps_m;
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            check(name, t + 1, e);
        end
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Standard full bring-up timeline for mask 3'b111 with 'd' at cycle 0, shifted by off.
    task automatic full_segs(input int off);
        sg(off + 1,  off + 4,  1'b0, 3'b000, 1'b1, 1'b0);
        sg(off + 5,  off + 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(off + 15, off + 16, 1'b1, 3'b001, 1'b1, 1'b0);
        sg(off + 17, off + 21, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(off + 22, off + 23, 1'b1, 3'b010, 1'b1, 1'b0);
        sg(off + 24, off + 28, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(off + 29, off + 30, 1'b1, 3'b100, 1'b1, 1'b0);
        sg(off + 31, off + 35, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(off + 36, off + 36, 1'b1, 3'b000, 1'b0, 1'b1);
        sg(off + 37, off + 40, 1'b1, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t z;
        z = '{en: 3'b000, sr: 3'b000, gh: 1'b0, ps: 1'b0, bz: 1'b0, dn: 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, z);
        rst = 1'b0;

        new_scn(); cmd(0, C_R);
        sg(1, 5, 1'b0, 3'b000, 1'b0, 1'b0);
        run("r_after_rst", 5);

        new_scn(); mask_at(0, 3'b000); cmd(0, C_D);
        sg(1, 4, 1'b0, 3'b000, 1'b1, 1'b0);
        sg(5, 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(15, 15, 1'b1, 3'b000, 1'b0, 1'b1);
        sg(16, 18, 1'b1, 3'b000, 1'b0, 1'b0);
        run("zero_mask", 18);

        new_scn(); mask_at(0, 3'b111); cmd(0, C_D); mask_at(10, 3'b000);
        full_segs(0);
        run("bringup", 40);

        new_scn(); mask_at(0, 3'b111); cmd(0, C_R);
        sg(1, 2, 1'b1, 3'b001, 1'b1, 1'b0);
        sg(3, 7, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(8, 9, 1'b1, 3'b010, 1'b1, 1'b0);
        sg(10, 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(15, 16, 1'b1, 3'b100, 1'b1, 1'b0);
        sg(17, 21, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(22, 22, 1'b1, 3'b000, 1'b0, 1'b1);
        sg(23, 25, 1'b1, 3'b000, 1'b0, 1'b0);
        run("reset_only", 25);

        new_scn(); mask_at(0, 3'b000); cmd(0, C_R);
        sg(1, 1, 1'b1, 3'b000, 1'b0, 1'b1);
        sg(2, 3, 1'b1, 3'b000, 1'b0, 1'b0);
        run("r_zero_mask", 3);

        new_scn(); mask_at(0, 3'b101); cmd(0, C_D); mask_at(18, 3'b111);
        sg(1, 4, 1'b0, 3'b000, 1'b1, 1'b0);
        sg(5, 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(15, 16, 1'b1, 3'b001, 1'b1, 1'b0);
        sg(17, 21, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(22, 23, 1'b1, 3'b100, 1'b1, 1'b0);
        sg(24, 28, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(29, 29, 1'b1, 3'b000, 1'b0, 1'b1);
        sg(30, 32, 1'b1, 3'b000, 1'b0, 1'b0);
        run("masked", 32);

        new_scn(); mask_at(0, 3'b111); cmd(0, C_D); cmd(16, C_D);
        sg(1, 4, 1'b0, 3'b000, 1'b1, 1'b0);
        sg(5, 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(15, 16, 1'b1, 3'b001, 1'b1, 1'b0);
        full_segs(16);
        run("restart", 54);

        new_scn(); mask_at(0, 3'b111); cmd(0, C_D); cmd(7, C_H); cmd(12, C_Z);
        cmd(20, C_S); cmd(25, C_P); cmd(38, C_C);
        full_segs(0);
        run("flags", 40);

        new_scn(); cmd(0, C_H); cmd(2, C_D); cmd(10, C_X);
        sg(1, 2, 1'b1, 3'b000, 1'b0, 1'b0);
        sg(3, 6, 1'b0, 3'b000, 1'b1, 1'b0);
        sg(7, 10, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(11, 16, 1'b0, 3'b000, 1'b0, 1'b0);
        run("shutdown", 16);

        new_scn(); mask_at(0, 3'b111); cmd(0, C_D); rst_at(15); cmd(20, C_D);
        sg(1, 4, 1'b0, 3'b000, 1'b1, 1'b0);
        sg(5, 14, 1'b1, 3'b000, 1'b1, 1'b0);
        sg(15, 15, 1'b1, 3'b001, 1'b1, 1'b0);
        sg(16, 20, 1'b0, 3'b000, 1'b0, 1'b0);
        full_segs(20);
        run("rst_mid_op", 58);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_bringup_sequencer.md
Name: tdc_bringup_sequencer

Overview:
Parametrised power-up and soft-reset sequencer for an array of NUM_CH TDC front-ends.
- Decodes single-byte ASCII commands from the upstream UART receiver.
- Drives a shared TDC enable, with a guaranteed low time before boot.
- After the boot wait, issues staggered, maskable, multi-cycle soft-reset pulses, one channel at a time.
- Also owns the go_home and pause flags and reports busy/done status to the host-side logic.

Parameters:
NUM_CH, 6, number of TDC channels (1..16)
CNT_W, 20, width of the shared delay counter; must hold the largest of the cycle parameters below
ENABLE_LOW_CYC, 16, cycles tdc_enable is held low before boot (>=1)
BOOT_CYC, 1000000, cycles waited after tdc_enable rises before the first soft reset (>=1)
RESET_PULSE_CYC, 2, width of each soft_reset pulse in cycles (>=1)
RESET_GAP_CYC, 3000, idle cycles after each channel's pulse (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  command byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
ch_mask  in  NUM_CH  1 = channel receives soft reset; sampled at sequence start
tdc_enable  out  NUM_CH  TDC enable, all bits identical
soft_reset  out  NUM_CH  one-hot soft-reset pulse
go_home  out  1  go-home request flag
pause  out  1  pause flag
busy  out  1  high in any state other than IDLE
seq_done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- All outputs are registered. Reset is synchronous and active-high, clock clk. On reset: state IDLE, tdc_enable=0, soft_reset=0, go_home=0, pause=0, busy=0, seq_done=0, counter=0, channel index=0.
- Latency: a command with rx_valid high at cycle N changes outputs at cycle N+1. Bytes with rx_valid low are ignored, as are unknown bytes.
- Command 'd' (full bring-up), accepted in any state, restarting any sequence in progress:
  - clears go_home; latches ch_mask; goes to EN_LOW with counter=0.
- Command 'r' (reset-only):
  - accepted only in IDLE with tdc_enable=1; latches ch_mask; goes to channel select (below). Ignored otherwise.
- Command 'x' (shutdown), any state:
  - tdc_enable=0, soft_reset=0, go to IDLE; no seq_done pulse.
- Commands 'h', 'c', 's', 'p' take effect in any state without disturbing the sequence:
  - 'h' sets go_home; 'c' clears go_home; 's' sets pause; 'p' clears pause.
- States:
  - IDLE: soft_reset=0.
  - EN_LOW: tdc_enable=0 for exactly ENABLE_LOW_CYC cycles, then BOOT_WAIT.
  - BOOT_WAIT: tdc_enable=1 for exactly BOOT_CYC cycles, then channel select.
  - RST_PULSE: soft_reset[ch]=1, all other bits 0, for exactly RESET_PULSE_CYC cycles, then RST_GAP.
  - RST_GAP: soft_reset=0 for exactly RESET_GAP_CYC cycles, then channel select starting from ch+1.
- Channel select is combinational and takes no cycle:
  - picks the lowest enabled channel >= start index and enters RST_PULSE.
  - If none remains, enters IDLE with seq_done=1 for that first IDLE cycle.
  - The final channel still receives its trailing gap.
  - An all-zero latched mask goes from BOOT_WAIT (or from 'r') directly to IDLE with a seq_done pulse.
- ch_mask changes mid-sequence have no effect until the next 'd' or 'r'.
- The counter resets to 0 on every state entry and compares against (param−1); no wrap is possible.
- Any mid-sequence output change is governed by the next-state logic: a 'd' during RST_PULSE drops soft_reset at N+1.

Test Plan:
All scenarios use NUM_CH=3, ENABLE_LOW_CYC=4, BOOT_CYC=10, RESET_PULSE_CYC=2, RESET_GAP_CYC=5, with rx_valid at cycle 0.
1. Full bring-up: 'd', mask 3'b111 ->
   - tdc_enable=0 cycles 1–4, =1 from cycle 5.
   - soft_reset=001 cycles 15–16, 010 cycles 22–23, 100 cycles 29–30.
   - seq_done=1 at cycle 36 only; busy=1 cycles 1–35.
2. Masked channel: 'd', mask 3'b101 ->
   - soft_reset=001 cycles 15–16, 100 cycles 22–23.
   - seq_done at cycle 29; bit 1 never asserted.
3. Reset-only and guard:
   - After scenario 1 completes, 'r' -> soft_reset=001 at the next 2 cycles, tdc_enable stays 1, and the sequence completes in 21 cycles.
   - 'r' straight after rst -> ignored: busy stays 0.
4. Restart and shutdown:
   - 'd' again at cycle 16 of scenario 1 -> soft_reset=0 and tdc_enable=0 at cycle 17; the full sequence is re-timed from 17.
   - 'x' mid-BOOT_WAIT -> tdc_enable=0 next cycle, IDLE, no seq_done.
5. Flags:
   - 'h' during BOOT_WAIT -> go_home=1 next cycle, sequence timing unchanged.
   - 's' then 'p' -> pause 1 then 0.
   - A later 'd' clears go_home.
   - Byte 'z' has no effect.
6. Reset mid-operation: rst asserted during RST_PULSE -> all outputs 0 next cycle; the 'd' that follows behaves exactly as in scenario 1.
